// File: rtl/sine_sweep_sequencer_if.sv
// rtl/sine_sweep_sequencer_if.sv - control, config and generator-side signals of the sine sweep sequencer
interface sine_sweep_if #(
    parameter int PHASE_WIDTH = 64,
    parameter int DIV_WIDTH   = 16,
    parameter int DWELL_WIDTH = 16
);
    logic                   start;
    logic                   abort;
    logic [DIV_WIDTH-1:0]   cfg_div;
    logic [PHASE_WIDTH-1:0] cfg_start_inc;
    logic [PHASE_WIDTH-1:0] cfg_stop_inc;
    logic [PHASE_WIDTH-1:0] cfg_step_inc;
    logic [DWELL_WIDTH-1:0] cfg_dwell;
    logic                   sample_clk_ce;
    logic [PHASE_WIDTH-1:0] phase_increment;
    logic                   busy;
    logic                   done;

    modport master (
        output start, abort, cfg_div, cfg_start_inc, cfg_stop_inc, cfg_step_inc, cfg_dwell,
        input  sample_clk_ce, phase_increment, busy, done
    );

    modport slave (
        input  start, abort, cfg_div, cfg_start_inc, cfg_stop_inc, cfg_step_inc, cfg_dwell,
        output sample_clk_ce, phase_increment, busy, done
    );
endinterface

// File: rtl/sine_sweep_sequencer.sv
// rtl/sine_sweep_sequencer.sv - linear phase-increment sweep and sample strobe for the sine generator (optional SINE_SWEEP_PINGPONG_EN)
module sine_sweep_sequencer #(
    parameter int PHASE_WIDTH = 64,
    parameter int DIV_WIDTH   = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic        clk,
    input  logic        arst,
    sine_sweep_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                 state, state_nxt;
    logic [DIV_WIDTH-1:0]   div_cnt, div_cnt_nxt, div_l, div_l_nxt;
    logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt, dwell_l, dwell_l_nxt;
    logic [PHASE_WIDTH-1:0] inc, inc_nxt, stop_l, stop_l_nxt, step_l, step_l_nxt;
    logic                   ce, ce_nxt, busy, done, done_nxt;
`ifdef SINE_SWEEP_PINGPONG_EN
    logic [PHASE_WIDTH-1:0] start_l, start_l_nxt;
    logic                   dir_down, dir_down_nxt;
`endif

    assign bus.sample_clk_ce   = ce;
    assign bus.phase_increment = inc;
    assign bus.busy            = busy;
    assign bus.done            = done;

    // State, counters, latched config and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            dwell_cnt <= '0;
            div_l     <= '0;
            dwell_l   <= '0;
            inc       <= '0;
            stop_l    <= '0;
            step_l    <= '0;
            ce        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SINE_SWEEP_PINGPONG_EN
            start_l   <= '0;
            dir_down  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_cnt_nxt;
            dwell_cnt <= dwell_cnt_nxt;
            div_l     <= div_l_nxt;
            dwell_l   <= dwell_l_nxt;
            inc       <= inc_nxt;
            stop_l    <= stop_l_nxt;
            step_l    <= step_l_nxt;
            ce        <= ce_nxt;
            busy      <= (state_nxt != IDLE);
            done      <= done_nxt;
`ifdef SINE_SWEEP_PINGPONG_EN
            start_l   <= start_l_nxt;
            dir_down  <= dir_down_nxt;
`endif
        end
    end

    // Next state: abort beats start, start beats divider/stepping; start is ignored while RUN
    always_comb begin
        state_nxt     = state;
        div_cnt_nxt   = div_cnt;
        dwell_cnt_nxt = dwell_cnt;
        div_l_nxt     = div_l;
        dwell_l_nxt   = dwell_l;
        inc_nxt       = inc;
        stop_l_nxt    = stop_l;
        step_l_nxt    = step_l;
        ce_nxt        = 1'b0;
        done_nxt      = 1'b0;
`ifdef SINE_SWEEP_PINGPONG_EN
        start_l_nxt   = start_l;
        dir_down_nxt  = dir_down;
`endif
        if (bus.abort) begin
            state_nxt     = IDLE;
            inc_nxt       = '0;
            div_cnt_nxt   = '0;
            dwell_cnt_nxt = '0;
`ifdef SINE_SWEEP_PINGPONG_EN
            dir_down_nxt  = 1'b0;
`endif
        end else if (bus.start && state != RUN) begin
            div_l_nxt     = bus.cfg_div;
            dwell_l_nxt   = bus.cfg_dwell;
            stop_l_nxt    = bus.cfg_stop_inc;
            step_l_nxt    = bus.cfg_step_inc;
            div_cnt_nxt   = '0;
            dwell_cnt_nxt = '0;
`ifdef SINE_SWEEP_PINGPONG_EN
            start_l_nxt   = bus.cfg_start_inc;
            dir_down_nxt  = 1'b0;
`endif
            if (bus.cfg_start_inc < bus.cfg_stop_inc) begin
                state_nxt = RUN;
                inc_nxt   = bus.cfg_start_inc;
            end else begin
                // Empty sweep: go straight to the endpoint and flag it
                state_nxt = HOLD;
                inc_nxt   = bus.cfg_stop_inc;
                done_nxt  = 1'b1;
            end
        end else if (state != IDLE) begin
            if (div_cnt == div_l) begin
                div_cnt_nxt = '0;
                ce_nxt      = 1'b1;
            end else begin
                div_cnt_nxt = div_cnt + DIV_WIDTH'(1);
            end
            // Each increment is held for dwell_l+1 strobes before stepping
            if (state == RUN && ce) begin
                if (dwell_cnt < dwell_l) begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_WIDTH'(1);
                end else begin
                    dwell_cnt_nxt = '0;
`ifdef SINE_SWEEP_PINGPONG_EN
                    if (!dir_down) begin
                        if ((stop_l - inc) <= step_l) begin
                            inc_nxt      = stop_l;
                            dir_down_nxt = 1'b1;
                            done_nxt     = 1'b1;
                        end else begin
                            inc_nxt = inc + step_l;
                        end
                    end else begin
                        if ((inc - start_l) <= step_l) begin
                            inc_nxt      = start_l;
                            dir_down_nxt = 1'b0;
                            done_nxt     = 1'b1;
                        end else begin
                            inc_nxt = inc - step_l;
                        end
                    end
`else
                    // Remaining distance compared first so the add can never overshoot or wrap
                    if ((stop_l - inc) <= step_l) begin
                        inc_nxt   = stop_l;
                        state_nxt = HOLD;
                        done_nxt  = 1'b1;
                    end else begin
                        inc_nxt = inc + step_l;
                    end
`endif
                end
            end
        end
    end

endmodule

// File: doc/sine_sweep_sequencer.md
Name: sine_sweep_sequencer

Overview:
- Controller that sequences the phase-accumulator sine generator.
- Produces the generator's sample_clk_ce strobe from a programmable clock divider.
- Steps the generator's phase_increment linearly from a start value to a stop value, with a programmable dwell per step. Used for DAC frequency-sweep tests and chirp generation.
- Sits between the configuration registers and the sine generator; the generator consumes the phase_increment and sample_clk_ce outputs directly.

Parameters:
- PHASE_WIDTH, 64, width of phase_increment and all increment config values
- DIV_WIDTH, 16, width of the sample-rate divider
- DWELL_WIDTH, 16, width of the dwell counter (sample strobes per step, minus 1)

Ports:
- clk  in  1  system clock
- arst  in  1  reset; asynchronous, active-high
- start  in  1  single-cycle request to latch config and begin a sweep
- abort  in  1  single-cycle request to stop and return to IDLE
- cfg_div  in  DIV_WIDTH  strobe period minus 1, in clk cycles
- cfg_start_inc  in  PHASE_WIDTH  first phase increment
- cfg_stop_inc  in  PHASE_WIDTH  final phase increment
- cfg_step_inc  in  PHASE_WIDTH  increment added per step
- cfg_dwell  in  DWELL_WIDTH  strobes per step, minus 1
- sample_clk_ce  out  1  registered strobe to the generator
- phase_increment  out  PHASE_WIDTH  registered increment to the generator
- busy  out  1  high in RUN and HOLD
- done  out  1  one-cycle pulse when the stop value is reached

Behaviour:
- Reset: state=IDLE, sample_clk_ce=0, phase_increment=0, busy=0, done=0, all counters=0, latched config=0.
- States: IDLE, RUN, HOLD. All config inputs are latched on an accepted start; later changes to cfg_* have no effect until the next accepted start.
- IDLE:
  - start=1 with cfg_start_inc < cfg_stop_inc: next cycle state=RUN, phase_increment=cfg_start_inc, div_cnt=0, dwell_cnt=0.
  - start=1 with cfg_start_inc >= cfg_stop_inc: next cycle state=HOLD, phase_increment=cfg_stop_inc, done=1 in that cycle.
- Divider (RUN and HOLD only):
  - div_cnt increments each clk; when div_cnt==div_l it wraps to 0.
  - sample_clk_ce=1 for exactly the cycle after the wrap edge, so strobe period = div_l+1 clks.
  - cfg_div=0 gives a continuous strobe.
  - The first strobe appears div_l+1 cycles after RUN is entered.
  - In IDLE the strobe is forced to 0 and div_cnt is held at 0.
- RUN stepping:
  - On each strobe cycle: if dwell_cnt < dwell_l, dwell_cnt++. Otherwise dwell_cnt=0 and a step occurs at the edge ending that strobe cycle.
  - Consequence: each increment value is consumed by exactly dwell_l+1 strobes.
- Step arithmetic (unsigned, no wrap):
  - If (stop_l - phase_increment) <= step_l: phase_increment=stop_l, state=HOLD, done=1 for one cycle.
  - Else: phase_increment += step_l.
  - step_l=0: remains in RUN at start_l indefinitely until abort; done never fires.
- HOLD:
  - phase_increment fixed at stop_l; strobes continue; busy=1.
  - start=1: relatch config and re-enter as if from IDLE. Counters reset; done is not re-pulsed unless start_inc >= stop_inc.
- start while in RUN: ignored.
- abort: from any state, next cycle state=IDLE, phase_increment=0, sample_clk_ce=0, busy=0, done=0. Abort takes priority over a simultaneous start and over a simultaneous step or done.
- arst mid-sweep: immediate return to reset values; no done pulse.
- busy, done, sample_clk_ce and phase_increment are all registered outputs.

Optional Feature:
- Macro: SINE_SWEEP_PINGPONG_EN.
- Defined:
  - On reaching stop_l, stay in RUN with direction=down instead of entering HOLD.
  - Descending rule: if (phase_increment - start_l) <= step_l, then phase_increment=start_l and direction=up; else phase_increment -= step_l.
  - done pulses one cycle at every endpoint reached. HOLD is unreachable, except via the start_inc >= stop_inc case.
  - direction resets to up on start, abort and arst.
- Undefined: single upward sweep then HOLD, exactly as in Behaviour; no direction register exists.

Test Plan:
- Reset check: assert arst mid-operation -> all outputs 0 within the same cycle; state IDLE after release.
- Basic sweep: div=3, dwell=1, start=100, step=50, stop=250.
  - Strobe every 4 clks.
  - Increments 100,150,200 held for 2 strobes each, then 250.
  - done exactly once, 1 cycle wide; busy stays 1.
- Clamp case: start=100, step=60, stop=200 -> sequence 100,160,200 (clamped, no overshoot); done once.
- Degenerate cases:
  - start=500, stop=500 -> HOLD the cycle after start, increment=500, done=1 once.
  - div=0 -> strobe high every cycle in RUN.
- Abort priority and ignored start:
  - abort asserted simultaneously with a step-completing strobe -> next cycle IDLE, increment=0, no done.
  - start pulsed during RUN -> no change to the sequence.
- Ping-pong (SINE_SWEEP_PINGPONG_EN defined), start=0, step=10, stop=30, dwell=0 -> 0,10,20,30,20,10,0,10...; done at each 30 and each 0.
